// File: rtl/pico_seq_decoder_if.sv
// Control bundle between program memory / handshake switch and the
// picoMIPS decoder: opcode and readyin in, datapath controls out.
interface pico_seq_decoder_if #(
  parameter int OPW = 3
);
  logic [OPW-1:0] opcode;
  logic           readyin;
  logic           PCincr;
  logic           PCrelbranch;
  logic           ALUfunc;
  logic           imm;
  logic           fetch;
  logic           show;
  logic           w;
  logic           addr1;
  logic           addr2;
  logic           busy;
  logic           err;

  // Driver side: supplies opcode and readyin, observes the controls.
  modport master (
    output opcode, readyin,
    input  PCincr, PCrelbranch, ALUfunc, imm, fetch, show, w,
           addr1, addr2, busy, err
  );

  // Decoder side.
  modport slave (
    input  opcode, readyin,
    output PCincr, PCrelbranch, ALUfunc, imm, fetch, show, w,
           addr1, addr2, busy, err
  );
endinterface

// File: rtl/pico_seq_decoder.sv
// Sequential picoMIPS decoder: opcode -> PC/ALU/mux/regfile controls, with a
// synchronised + debounced ready input, multi-cycle MULI stall and a sticky
// halt on illegal opcodes. Controls are combinational from state, opcode,
// filtered ready and the multiply counter.
module pico_seq_decoder #(
  parameter int OPW     = 3,
  parameter int MUL_LAT = 1,
  parameter int DEB     = 4
) (
  input  logic                 clk,
  input  logic                 nReset,
  pico_seq_decoder_if.slave    bus
);
  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_MULT = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  localparam logic [2:0] OP_ADD    = 3'd0;
  localparam logic [2:0] OP_ADDI   = 3'd1;
  localparam logic [2:0] OP_MULI   = 3'd2;
  localparam logic [2:0] OP_ADDF   = 3'd3;
  localparam logic [2:0] OP_SHOW   = 3'd4;
  localparam logic [2:0] OP_WAIT1  = 3'd5;
  localparam logic [2:0] OP_WAIT0  = 3'd6;
  localparam logic [2:0] OP_RETURN = 3'd7;

  // Debounce compare value: the counter "reaches DEB" on the cycle it would
  // step from DEB-1 to DEB, so the filtered value updates 2+DEB cycles after
  // a readyin edge.
  localparam logic [7:0] DEB_LAST = (DEB == 0) ? 8'd0 : 8'(DEB - 1);
  localparam logic [3:0] MUL_INIT = 4'(MUL_LAT - 1);

  logic       r_s1, r_s2, r_readyq;
  logic [7:0] r_dcnt;
  logic [1:0] r_state;
  logic [3:0] r_mcnt;

  logic [1:0] w_state_next;
  logic [3:0] w_mcnt_next;
  logic       w_legal;
  logic [2:0] w_op3;
  logic       w_pcincr, w_pcrel, w_alufunc, w_imm, w_fetch, w_show;
  logic       w_wen, w_addr1, w_addr2, w_busy, w_err;

  // Encodings are zero-extended: any set bit above bit 2 is illegal.
  generate
    if (OPW > 3) begin : g_wide_op
      assign w_legal = ~|bus.opcode[OPW-1:3];
    end else begin : g_narrow_op
      assign w_legal = 1'b1;
    end
  endgenerate
  assign w_op3 = bus.opcode[2:0];

  // Two-flop synchroniser followed by a persistence filter on readyin.
  always_ff @(posedge clk) begin
    if (!nReset) begin
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_readyq <= 1'b0;
      r_dcnt   <= 8'd0;
    end else begin
      r_s1 <= bus.readyin;
      r_s2 <= r_s1;
      if (r_s2 == r_readyq) begin
        r_dcnt <= 8'd0;
      end else if (DEB == 0 || r_dcnt == DEB_LAST) begin
        r_readyq <= r_s2;
        r_dcnt   <= 8'd0;
      end else begin
        r_dcnt <= r_dcnt + 8'd1;
      end
    end
  end

  // Control decode and next-state selection.
  always_comb begin
    w_state_next = r_state;
    w_mcnt_next  = r_mcnt;
    w_pcincr     = 1'b0;
    w_pcrel      = 1'b0;
    w_alufunc    = 1'b0;
    w_imm        = 1'b0;
    w_fetch      = 1'b0;
    w_show       = 1'b0;
    w_wen        = 1'b0;
    w_addr1      = 1'b0;
    w_addr2      = 1'b0;
    w_busy       = 1'b0;
    w_err        = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (!w_legal) begin
          w_state_next = ST_HALT;
        end else begin
          case (w_op3)
            OP_ADD: begin
              w_wen    = 1'b1;
              w_pcincr = 1'b1;
            end
            OP_ADDI: begin
              w_wen    = 1'b1;
              w_imm    = 1'b1;
              w_pcincr = 1'b1;
            end
            OP_MULI: begin
              w_imm     = 1'b1;
              w_alufunc = 1'b1;
              if (MUL_LAT == 1) begin
                w_wen    = 1'b1;
                w_pcincr = 1'b1;
              end else begin
                w_busy       = 1'b1;
                w_state_next = ST_MULT;
                w_mcnt_next  = MUL_INIT;
              end
            end
            OP_ADDF: begin
              w_wen    = 1'b1;
              w_imm    = 1'b1;
              w_fetch  = 1'b1;
              w_addr1  = 1'b1;
              w_pcincr = 1'b1;
            end
            OP_SHOW: begin
              w_show   = 1'b1;
              w_addr2  = 1'b1;
              w_pcincr = 1'b1;
            end
            OP_WAIT1: begin
              w_imm    = 1'b1;
              w_pcrel  = r_readyq;
              w_pcincr = ~r_readyq;
            end
            OP_WAIT0: begin
              w_imm    = 1'b1;
              w_pcrel  = ~r_readyq;
              w_pcincr = r_readyq;
            end
            OP_RETURN: begin
              w_imm   = 1'b1;
              w_pcrel = 1'b1;
            end
            default: ;
          endcase
        end
      end
      ST_MULT: begin
        // Opcode is ignored; the last MULT cycle carries the single write.
        w_imm       = 1'b1;
        w_alufunc   = 1'b1;
        w_mcnt_next = r_mcnt - 4'd1;
        if (r_mcnt > 4'd1) begin
          w_busy = 1'b1;
        end else begin
          w_wen        = 1'b1;
          w_pcincr     = 1'b1;
          w_state_next = ST_RUN;
        end
      end
      ST_HALT: begin
        w_err = 1'b1;
      end
      default: begin
        w_state_next = ST_RUN;
      end
    endcase
  end

  // State and multiply-counter registers.
  always_ff @(posedge clk) begin
    if (!nReset) begin
      r_state <= ST_RUN;
      r_mcnt  <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_mcnt  <= w_mcnt_next;
    end
  end

  // All controls are held low while reset is asserted.
  assign bus.PCincr      = nReset & w_pcincr;
  assign bus.PCrelbranch = nReset & w_pcrel;
  assign bus.ALUfunc     = nReset & w_alufunc;
  assign bus.imm         = nReset & w_imm;
  assign bus.fetch       = nReset & w_fetch;
  assign bus.show        = nReset & w_show;
  assign bus.w           = nReset & w_wen;
  assign bus.addr1       = nReset & w_addr1;
  assign bus.addr2       = nReset & w_addr2;
  assign bus.busy        = nReset & w_busy;
  assign bus.err         = nReset & w_err;
endmodule

// File: tb/tb_pico_seq_decoder.sv
// Bench for pico_seq_decoder (OPW=4, MUL_LAT=4, DEB=4) with a cycle-level
// reference model built from the decode table and a windowed ready filter.
module tb_pico_seq_decoder;
  localparam int OPW     = 4;
  localparam int MUL_LAT = 4;
  localparam int DEB     = 4;

  logic clk = 1'b0;
  logic nReset;
  int   tests_run = 0;
  int   tests_failed = 0;

  pico_seq_decoder_if #(.OPW(OPW)) bus ();

  pico_seq_decoder #(.OPW(OPW), .MUL_LAT(MUL_LAT), .DEB(DEB)) dut (
    .clk    (clk),
    .nReset (nReset),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Vector bit order: PCincr PCrelbranch ALUfunc imm fetch show w addr1 addr2 busy err
  localparam int B_PC = 10, B_BR = 9, B_W = 4, B_BUSY = 1;

  // Reference model state: mode 0=run 1=multiply 2=halted.
  int   m_mode = 0;
  int   m_pos  = 0;
  logic m_rq   = 1'b0;
  logic hist[$];

  function automatic logic hget(int k);
    if (k >= 1 && k <= hist.size()) return hist[k-1];
    return 1'b0;
  endfunction

  function automatic logic [10:0] model_exp(logic [3:0] op, logic rst_n);
    logic pc, br, alu, im, fe, sh, wr, a1, a2, bz, er;
    {pc, br, alu, im, fe, sh, wr, a1, a2, bz, er} = 11'd0;
    if (rst_n) begin
      if (m_mode == 2) begin
        er = 1'b1;
      end else if (m_mode == 1) begin
        alu = 1'b1; im = 1'b1;
        if (m_pos == MUL_LAT - 1) begin wr = 1'b1; pc = 1'b1; end
        else bz = 1'b1;
      end else if (op < 8) begin
        case (op)
          0: begin wr = 1; pc = 1; end
          1: begin wr = 1; im = 1; pc = 1; end
          2: begin
            im = 1; alu = 1;
            if (MUL_LAT == 1) begin wr = 1; pc = 1; end else bz = 1;
          end
          3: begin wr = 1; im = 1; fe = 1; a1 = 1; pc = 1; end
          4: begin sh = 1; a2 = 1; pc = 1; end
          5: begin im = 1; if (m_rq) br = 1; else pc = 1; end
          6: begin im = 1; if (!m_rq) br = 1; else pc = 1; end
          default: begin im = 1; br = 1; end
        endcase
      end
    end
    return {pc, br, alu, im, fe, sh, wr, a1, a2, bz, er};
  endfunction

  // Advance the model across one rising edge.
  task automatic model_edge(input logic [3:0] op, input logic rdy, input logic rst_n);
    int n, lo, hi;
    logic all_diff;
    if (!rst_n) begin
      m_mode = 0; m_pos = 0; m_rq = 1'b0; hist.delete();
      return;
    end
    // Filtered ready flips once the synchronised input (two samples late)
    // has disagreed with it for DEB consecutive samples.
    hist.push_back(rdy);
    n  = hist.size();
    hi = n - 2;
    lo = (DEB == 0) ? n - 2 : n - 1 - DEB;
    all_diff = 1'b1;
    for (int k = lo; k <= hi; k++) if (hget(k) == m_rq) all_diff = 1'b0;
    if (all_diff) m_rq = ~m_rq;
    case (m_mode)
      0: begin
        if (op >= 8) m_mode = 2;
        else if (op == 2 && MUL_LAT > 1) begin m_mode = 1; m_pos = 1; end
      end
      1: begin
        if (m_pos == MUL_LAT - 1) m_mode = 0;
        else m_pos = m_pos + 1;
      end
      default: ;
    endcase
  endtask

  // One clock: drive inputs, sample outputs mid-cycle, then cross the edge.
  task automatic step(input logic [3:0] op, input logic rdy, input logic rst_n,
                      output logic [10:0] exp_v, output logic [10:0] act_v);
    bus.opcode  = op;
    bus.readyin = rdy;
    nReset      = rst_n;
    @(negedge clk);
    act_v = {bus.PCincr, bus.PCrelbranch, bus.ALUfunc, bus.imm, bus.fetch, bus.show,
             bus.w, bus.addr1, bus.addr2, bus.busy, bus.err};
    exp_v = model_exp(op, rst_n);
    @(posedge clk);
    model_edge(op, rdy, rst_n);
    #1;
  endtask

  task automatic test_reset();
    logic [10:0] e, a;
    step(4'd0, 1'b0, 1'b0, e, a);
    tests_run++;
    if (a !== 11'd0) begin tests_failed++; $display("FAIL reset_outputs: got %b expected %b", a, 11'd0); end
    step(4'd0, 1'b0, 1'b0, e, a);
    step(4'd0, 1'b0, 1'b1, e, a);
    tests_run++;
    if (a !== 11'b10000010000) begin tests_failed++; $display("FAIL reset_first_add: got %b expected %b", a, 11'b10000010000); end
    $display("[TB] test_reset done");
  endtask

  task automatic test_decode();
    logic [10:0] e, a;
    logic [3:0]  ops [4] = '{4'd0, 4'd1, 4'd3, 4'd4};
    logic [10:0] want [4] = '{11'b10000010000, 11'b10010010000,
                              11'b10011011000, 11'b10000100100};
    step(4'd0, 1'b0, 1'b0, e, a);
    for (int i = 0; i < 4; i++) begin
      step(ops[i], 1'b0, 1'b1, e, a);
      tests_run++;
      if (a !== want[i]) begin tests_failed++; $display("FAIL decode_op%0d: got %b expected %b", ops[i], a, want[i]); end
      $display("[TB] decode op=%0d ctrl=%b", ops[i], a);
    end
    for (int i = 0; i < 20; i++) begin
      logic [3:0] op;
      op = ops[$urandom_range(0, 3)];
      step(op, 1'b0, 1'b1, e, a);
      tests_run++;
      if (a !== e) begin tests_failed++; $display("FAIL decode_rand op=%0d: got %b expected %b", op, a, e); end
    end
  endtask

  task automatic test_mult();
    logic [10:0] e, a;
    logic want_busy [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    step(4'd0, 1'b0, 1'b0, e, a);
    for (int i = 0; i < MUL_LAT; i++) begin
      step(4'd2, 1'b0, 1'b1, e, a);
      tests_run++;
      if (a[B_BUSY] !== want_busy[i] || a[B_W] !== ~want_busy[i] || a[B_PC] !== ~want_busy[i] || a[8] !== 1'b1) begin
        tests_failed++;
        $display("FAIL mult_cycle%0d: got %b expected busy=%b w/PCincr=%b ALUfunc=1", i, a, want_busy[i], ~want_busy[i]);
      end
      tests_run++;
      if (a !== e) begin tests_failed++; $display("FAIL mult_model%0d: got %b expected %b", i, a, e); end
      $display("[TB] mult cycle %0d ctrl=%b", i, a);
    end
    step(4'd1, 1'b0, 1'b1, e, a);
    tests_run++;
    if (a !== 11'b10010010000) begin tests_failed++; $display("FAIL mult_resume: got %b expected %b", a, 11'b10010010000); end
  endtask

  task automatic test_wait1();
    logic [10:0] e, a;
    int seen;
    logic glitch_seen;
    step(4'd0, 1'b0, 1'b0, e, a);
    for (int i = 0; i < 3; i++) step(4'd5, 1'b0, 1'b1, e, a);
    tests_run++;
    if (a !== 11'b10010000000) begin tests_failed++; $display("FAIL wait1_idle: got %b expected %b", a, 11'b10010000000); end
    seen = -1;
    for (int i = 0; i < 20 && seen < 0; i++) begin
      step(4'd5, 1'b1, 1'b1, e, a);
      tests_run++;
      if (a !== e) begin tests_failed++; $display("FAIL wait1_model%0d: got %b expected %b", i, a, e); end
      if (a[B_BR] === 1'b1) seen = i;
    end
    tests_run++;
    if (seen != 2 + DEB) begin tests_failed++; $display("FAIL wait1_latency: got %0d expected %0d", seen, 2 + DEB); end
    $display("[TB] wait1 branch after %0d cycles", seen);
    // Three-cycle glitch must never reach the filtered value.
    step(4'd0, 1'b0, 1'b0, e, a);
    glitch_seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step(4'd5, (i < 3) ? 1'b1 : 1'b0, 1'b1, e, a);
      if (a[B_BR] === 1'b1) glitch_seen = 1'b1;
    end
    tests_run++;
    if (glitch_seen !== 1'b0) begin tests_failed++; $display("FAIL wait1_glitch: got branch=%b expected 0", glitch_seen); end
  endtask

  task automatic test_wait0();
    logic [10:0] e, a;
    int seen;
    step(4'd0, 1'b0, 1'b0, e, a);
    step(4'd6, 1'b0, 1'b1, e, a);
    tests_run++;
    if (a[B_BR] !== 1'b1 || a[B_PC] !== 1'b0) begin tests_failed++; $display("FAIL wait0_hold: got %b expected PCrelbranch=1 PCincr=0", a); end
    seen = -1;
    for (int i = 0; i < 20 && seen < 0; i++) begin
      step(4'd6, 1'b1, 1'b1, e, a);
      if (a[B_PC] === 1'b1) seen = i;
    end
    tests_run++;
    if (seen != 2 + DEB) begin tests_failed++; $display("FAIL wait0_latency: got %0d expected %0d", seen, 2 + DEB); end
    $display("[TB] wait0 release after %0d cycles", seen);
  endtask

  task automatic test_illegal();
    logic [10:0] e, a;
    logic [3:0] later [3] = '{4'd0, 4'd1, 4'd4};
    step(4'd0, 1'b0, 1'b0, e, a);
    step(4'd9, 1'b0, 1'b1, e, a);
    tests_run++;
    if (a !== 11'd0) begin tests_failed++; $display("FAIL illegal_cycle: got %b expected %b", a, 11'd0); end
    for (int i = 0; i < 3; i++) begin
      step(later[i], 1'b0, 1'b1, e, a);
      tests_run++;
      if (a !== 11'd1) begin tests_failed++; $display("FAIL halt_op%0d: got %b expected %b", later[i], a, 11'd1); end
    end
    step(4'd0, 1'b0, 1'b0, e, a);
    step(4'd0, 1'b0, 1'b1, e, a);
    tests_run++;
    if (a !== 11'b10000010000) begin tests_failed++; $display("FAIL illegal_recover: got %b expected %b", a, 11'b10000010000); end
    $display("[TB] illegal opcode halt and recovery checked");
  endtask

  task automatic test_reset_mid_mult();
    logic [10:0] e, a;
    logic wseen;
    step(4'd0, 1'b0, 1'b0, e, a);
    wseen = 1'b0;
    step(4'd2, 1'b0, 1'b1, e, a); wseen |= a[B_W];
    step(4'd2, 1'b0, 1'b1, e, a); wseen |= a[B_W];
    step(4'd2, 1'b0, 1'b0, e, a); wseen |= a[B_W];
    step(4'd4, 1'b0, 1'b1, e, a); wseen |= a[B_W];
    tests_run++;
    if (wseen !== 1'b0) begin tests_failed++; $display("FAIL abort_no_w: got w=%b expected 0", wseen); end
    tests_run++;
    if (a !== 11'b10000100100) begin tests_failed++; $display("FAIL abort_run: got %b expected %b", a, 11'b10000100100); end
    $display("[TB] reset during multiply checked");
  endtask

  task automatic test_random();
    logic [10:0] e, a;
    logic rdy, rst_n;
    logic [3:0] op;
    rdy = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) rdy = ~rdy;
      rst_n = ($urandom_range(0, 49) != 0);
      op = ($urandom_range(0, 59) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
      step(op, rdy, rst_n, e, a);
      tests_run++;
      if (a !== e) begin tests_failed++; $display("FAIL random%0d op=%0d rdy=%b rst_n=%b: got %b expected %b", i, op, rdy, rst_n, a, e); end
      if (a[B_PC] === 1'b1 && a[B_BR] === 1'b1) begin
        tests_run++; tests_failed++;
        $display("FAIL random_pc_exclusive%0d: got both PCincr and PCrelbranch", i);
      end
    end
    $display("[TB] random sequence of 400 cycles checked");
  endtask

  initial begin
    nReset      = 1'b0;
    bus.opcode  = '0;
    bus.readyin = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_decode();
    test_mult();
    test_wait1();
    test_wait0();
    test_illegal();
    test_reset_mid_mult();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
